i2s2_slave_port: RTL and testbench

I2S2_SLAVE_PORT -- requirements
Module: i2s2_slave_port

---
 rtl/i2s2_slave_port_if.sv | 28 ++
 rtl/i2s2_slave_port.sv | 106 ++++++++++
 tb/tb_i2s2_slave_port.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2s2_slave_port_if.sv
// i2s2_slave_port_if: I2S serial lines plus RX/TX sample streams of the I2S slave port
//   SCLK_IN, LRCK_IN, SDIN : external bit clock, word select, ADC data (async to MCLK)
//   SDOUT                  : serial data to DAC
//   RX_DATA/RX_CH/RX_VALID : received 24-bit word, its channel, one-cycle update strobe
//   TX_LEFT/TX_RIGHT       : stereo sample offered with TX_VALID, taken when TX_READY
//   TX_UNDERRUN            : one-cycle strobe when a frame starts without a new sample
interface i2s2_slave_port_if;
    logic        SCLK_IN;
    logic        LRCK_IN;
    logic        SDIN;
    logic        SDOUT;
    logic [23:0] RX_DATA;
    logic        RX_CH;
    logic        RX_VALID;
    logic [23:0] TX_LEFT;
    logic [23:0] TX_RIGHT;
    logic        TX_VALID;
    logic        TX_READY;
    logic        TX_UNDERRUN;
    modport slave (
        input  SCLK_IN, LRCK_IN, SDIN, TX_LEFT, TX_RIGHT, TX_VALID,
        output SDOUT, RX_DATA, RX_CH, RX_VALID, TX_READY, TX_UNDERRUN
    );
    modport master (
        output SCLK_IN, LRCK_IN, SDIN, TX_LEFT, TX_RIGHT, TX_VALID,
        input  SDOUT, RX_DATA, RX_CH, RX_VALID, TX_READY, TX_UNDERRUN
    );
endinterface

// File: rtl/i2s2_slave_port.sv
// i2s2_slave_port: 24-bit I2S slave transceiver clocked by MCLK, oversampling SCLK/LRCK
//   MCLK  : system clock, all logic on its rising edge
//   RST_N : asynchronous active-low reset
//   bus   : i2s2_slave_port_if.slave (serial lines, RX word stream, TX sample handshake)
module i2s2_slave_port (
    input logic MCLK,
    input logic RST_N,
    i2s2_slave_port_if.slave bus
);
    logic [1:0]  sclk_s, lrck_s, sdin_s;
    logic        sclk_d, lrck_d, armed, rdy_en;
    logic [4:0]  cnt, tx_idx, pad;
    logic [23:0] rx_sr, rx_data, pend_l, pend_r, act_l, act_r, tx_word;
    logic        rx_ch, rx_valid, pend_full, underrun, sdout;
    logic        sclk_rise, sclk_fall, lrck_edge, fs, tx_ready, xfer;
    always_comb begin
        // SCLK events only count once the first LRCK edge has framed the stream
        sclk_rise = armed & sclk_s[1] & ~sclk_d;
        sclk_fall = armed & ~sclk_s[1] & sclk_d;
        lrck_edge = lrck_s[1] ^ lrck_d;
        fs        = lrck_edge & lrck_d;
        // frame start frees the slot in the same cycle, so a waiting sample can land at once
        tx_ready  = rdy_en & (~pend_full | fs);
        xfer      = bus.TX_VALID & tx_ready;
        tx_word   = lrck_s[1] ? act_r : act_l;
        tx_idx    = 5'd24 - cnt;
        // left-align a short word: cnt-1 bits arrived, so shift by 24-(cnt-1)
        pad       = 5'd25 - cnt;
    end
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_s    <= '0;
            lrck_s    <= '0;
            sdin_s    <= '0;
            sclk_d    <= 1'b0;
            lrck_d    <= 1'b0;
            armed     <= 1'b0;
            rdy_en    <= 1'b0;
            cnt       <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_ch     <= 1'b0;
            rx_valid  <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            pend_full <= 1'b0;
            act_l     <= '0;
            act_r     <= '0;
            underrun  <= 1'b0;
            sdout     <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[0], bus.SCLK_IN};
            lrck_s    <= {lrck_s[0], bus.LRCK_IN};
            sdin_s    <= {sdin_s[0], bus.SDIN};
            sclk_d    <= sclk_s[1];
            lrck_d    <= lrck_s[1];
            armed     <= armed | lrck_edge;
            rdy_en    <= 1'b1;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            if (lrck_edge) begin
                cnt   <= '0;
                rx_sr <= '0;
                // cnt 2..24 means 1..23 data bits: flush them; cnt 25+ was already emitted
                if (armed && cnt >= 5'd2 && cnt <= 5'd24) begin
                    rx_data  <= rx_sr << pad;
                    rx_ch    <= lrck_d;
                    rx_valid <= 1'b1;
                end
            end else if (sclk_rise) begin
                if (cnt != 5'd31)
                    cnt <= cnt + 5'd1;
                if (cnt >= 5'd1 && cnt <= 5'd24)
                    rx_sr <= {rx_sr[22:0], sdin_s[1]};
                if (cnt == 5'd24) begin
                    rx_data  <= {rx_sr[22:0], sdin_s[1]};
                    rx_ch    <= lrck_s[1];
                    rx_valid <= 1'b1;
                end
            end
            if (lrck_edge)
                sdout <= 1'b0;
            else if (sclk_fall)
                sdout <= (cnt >= 5'd1 && cnt <= 5'd24) ? tx_word[tx_idx] : 1'b0;
            if (fs) begin
                if (pend_full) begin
                    act_l <= pend_l;
                    act_r <= pend_r;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (xfer) begin
                pend_l <= bus.TX_LEFT;
                pend_r <= bus.TX_RIGHT;
            end
            pend_full <= xfer | (pend_full & ~fs);
        end
    end
    assign bus.SDOUT       = sdout;
    assign bus.RX_DATA     = rx_data;
    assign bus.RX_CH       = rx_ch;
    assign bus.RX_VALID    = rx_valid;
    assign bus.TX_READY    = tx_ready;
    assign bus.TX_UNDERRUN = underrun;
endmodule

// File: tb/tb_i2s2_slave_port.sv
// tb_i2s2_slave_port: scoreboard bench driving an I2S master (SCLK = MCLK/8) into i2s2_slave_port
module tb_i2s2_slave_port;
    logic MCLK = 1'b0;
    logic RST_N = 1'b0;
    i2s2_slave_port_if bus();
    i2s2_slave_port dut (.MCLK(MCLK), .RST_N(RST_N), .bus(bus));
    always #5 MCLK = ~MCLK;
    int total = 0;
    int bad = 0;
    int und_cnt = 0;
    time ref_t = 0;
    logic [24:0] rx_q[$];
    logic [23:0] tx_q[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    initial forever begin
        @(negedge MCLK);
        if (bus.TX_UNDERRUN)
            und_cnt++;
        if (bus.RX_VALID) begin
            chk("rx_expected", rx_q.size() != 0, 1);
            if (rx_q.size() != 0) begin
                chk("rx_word", {7'd0, bus.RX_CH, bus.RX_DATA}, {7'd0, rx_q.pop_front()});
                chk("rx_lat", ($time > ref_t) && ($time - ref_t <= 40), 1);
            end
        end
    end
    task automatic tx_push(input logic [23:0] l, input logic [23:0] r);
        int k = 0;
        @(negedge MCLK);
        bus.TX_LEFT  = l;
        bus.TX_RIGHT = r;
        bus.TX_VALID = 1'b1;
        while (!bus.TX_READY && k < 5000) begin
            @(negedge MCLK);
            k++;
        end
        chk("tx_accept", bus.TX_READY, 1);
        @(negedge MCLK);
        bus.TX_VALID = 1'b0;
    endtask
    task automatic mid_reset(input time tr);
        #10 RST_N = 1'b0;
        #1;
        chk("mrst_sdout", bus.SDOUT, 0);
        chk("mrst_ready", bus.TX_READY, 0);
        chk("mrst_valid", bus.RX_VALID, 0);
        #9 RST_N = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        chk("mrst_ready1", bus.TX_READY, 1);
        chk("mrst_sdout1", bus.SDOUT, 0);
        #(tr + 40 - $time);
    endtask
    // one half-frame of nbits SCLK periods; bit 0 is the I2S delay bit
    task automatic half(input logic ch, input logic [23:0] word, input int nbits,
                        input logic rx_on, input logic tx_on, input logic [23:0] tx_exp,
                        input int rst_at);
        logic [30:0] got = '0;
        time tr;
        bus.LRCK_IN = ch;
        ref_t = $time;
        if (rx_on && nbits >= 25)
            rx_q.push_back({ch, word});
        else if (rx_on && nbits > 1)
            rx_q.push_back({ch, word & ~(24'hFFFFFF >> (nbits - 1))});
        if (tx_on)
            tx_q.push_back(tx_exp);
        for (int i = 0; i < nbits; i++) begin
            bus.SDIN = (i >= 1 && i <= 24) ? word[24 - i] : 1'b0;
            #40;
            bus.SCLK_IN = 1'b1;
            tr = $time;
            if (i == 24)
                ref_t = $time;
            if (i >= 1 && i <= 31)
                got = {got[29:0], bus.SDOUT};
            if (i == rst_at)
                mid_reset(tr);
            else
                #40;
            bus.SCLK_IN = 1'b0;
        end
        if (tx_on)
            chk("tx_word", {1'b0, got}, {1'b0, tx_q.pop_front(), 7'd0});
    endtask
    function automatic logic [23:0] rnd();
        return 24'($urandom_range(0, 32'hFFFFFF));
    endfunction
    initial begin
        bus.SCLK_IN  = 1'b0;
        bus.LRCK_IN  = 1'b0;
        bus.SDIN     = 1'b0;
        bus.TX_LEFT  = '0;
        bus.TX_RIGHT = '0;
        bus.TX_VALID = 1'b0;
        @(negedge MCLK);
        @(negedge MCLK);
        chk("rst_rx_data", {8'd0, bus.RX_DATA}, 0);
        chk("rst_rx_ch", bus.RX_CH, 0);
        chk("rst_rx_valid", bus.RX_VALID, 0);
        chk("rst_sdout", bus.SDOUT, 0);
        chk("rst_underrun", bus.TX_UNDERRUN, 0);
        chk("rst_ready", bus.TX_READY, 0);
        #12 RST_N = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        chk("ready_after_rst", bus.TX_READY, 1);
        tx_push(24'hFFF000, 24'h00000F);
        chk("ready_slot_full", bus.TX_READY, 0);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h0, -1);
        half(1'b0, 24'hA5A5A5, 32, 1'b1, 1'b1, 24'hFFF000, -1);
        half(1'b1, 24'h123456, 32, 1'b1, 1'b1, 24'h00000F, -1);
        chk("ready_frame_start", bus.TX_READY, 1);
        chk("und_none", und_cnt, 0);
        tx_push(24'h800001, 24'h800001);
        for (int f = 0; f < 3; f++) begin
            half(1'b0, rnd(), 32, 1'b1, 1'b1, 24'h800001, -1);
            half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h800001, -1);
            chk("und_replay", und_cnt, f);
        end
        tx_push(24'h111111, 24'h222222);
        fork
            tx_push(24'h333333, 24'h444444);
        join_none
        half(1'b0, rnd(), 32, 1'b1, 1'b1, 24'h111111, -1);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h222222, -1);
        chk("ready_b_pending", bus.TX_READY, 0);
        chk("und_back2back", und_cnt, 2);
        half(1'b0, rnd(), 32, 1'b1, 1'b1, 24'h333333, -1);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h444444, -1);
        chk("ready_b_played", bus.TX_READY, 1);
        chk("und_b_played", und_cnt, 2);
        half(1'b0, 24'hFFFFFF, 17, 1'b1, 1'b0, 24'h0, -1);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h444444, -1);
        chk("und_partial", und_cnt, 3);
        tx_push(24'hC0C0C0, 24'hC0C0C0);
        fork
            tx_push(24'hD0D0D0, 24'hD0D0D0);
        join_none
        half(1'b0, rnd(), 32, 1'b0, 1'b0, 24'h0, 10);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h0, -1);
        half(1'b0, rnd(), 32, 1'b1, 1'b1, 24'h0, -1);
        half(1'b1, rnd(), 32, 1'b1, 1'b1, 24'h0, -1);
        chk("und_after_rst", und_cnt, 4);
        repeat (10) @(negedge MCLK);
        chk("rx_q_drained", rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
